fib_scroll_gen: RTL and testbench

Parameterised Fibonacci table generator and two-row LCD text formatter. It drives the row_a/row_b inputs of the existing LCD driver.
- After a start pulse, fills an internal table with NUM_TERMS terms at one term per cycle.
- Then scrolls through the table, one line per TICK_PERIOD cycles.
- Direction toggle and pause are run-time inputs.
- Generalises the single-width, fixed-depth, auto-start display to any value width, depth and scroll rate, and adds saturation/overflow reporting.

---
 rtl/fib_lcd_pkg.sv | 17 +
 rtl/fib_row_fmt.sv | 24 ++
 rtl/fib_scroll_gen.sv | 145 ++++++++++++++
 tb/tb_fib_scroll_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_lcd_pkg.sv
// Shared types, banner text and hex-to-ASCII helper for the Fibonacci LCD scroller.
package fib_lcd_pkg;

  localparam int ROW_W = 128;

  typedef enum logic [1:0] {IDLE, GEN, DISP} state_t;

  localparam logic [ROW_W-1:0] BANNER_A = "Press BTN3 to   ";
  localparam logic [ROW_W-1:0] BANNER_B = "show a message..";

  // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/fib_row_fmt.sv
// Formats one LCD row as "#II:VVVV..." (uppercase hex), left-aligned and space-padded to 16 chars.
module fib_row_fmt
  import fib_lcd_pkg::*;
#(
  parameter int VAL_W = 16
)(
  input  logic [7:0]       idx,
  input  logic [VAL_W-1:0] val,
  output logic [ROW_W-1:0] row
);

  localparam int ND = VAL_W / 4;

  always_comb begin
    row = {16{8'h20}};
    row[ROW_W-1  -: 8] = 8'h23;
    row[ROW_W-9  -: 8] = nib2ascii(idx[7:4]);
    row[ROW_W-17 -: 8] = nib2ascii(idx[3:0]);
    row[ROW_W-25 -: 8] = 8'h3A;
    for (int i = 0; i < ND; i++)
      row[ROW_W-33-8*i -: 8] = nib2ascii(val[VAL_W-1-4*i -: 4]);
  end

endmodule

// File: rtl/fib_scroll_gen.sv
// Fibonacci table generator with saturation and a two-row scrolling LCD text formatter.
// Optional build macro LUCAS_SEED_EN adds seed_sel to select Lucas seeds (2, 1) at start.
module fib_scroll_gen
  import fib_lcd_pkg::*;
#(
  parameter int NUM_TERMS   = 25,
  parameter int VAL_W       = 16,
  parameter int TICK_PERIOD = 100000000
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             dir_toggle,
  input  logic             pause,
`ifdef LUCAS_SEED_EN
  input  logic             seed_sel,
`endif
  output logic [ROW_W-1:0] row_a,
  output logic [ROW_W-1:0] row_b,
  output logic [7:0]       cur_idx,
  output logic             busy,
  output logic             ovf
);

  localparam int               AW       = $clog2(NUM_TERMS + 1);
  localparam int               TW       = $clog2(TICK_PERIOD);
  localparam logic [7:0]       LAST     = 8'(NUM_TERMS);
  localparam logic [TW-1:0]    TICK_MAX = TW'(TICK_PERIOD - 1);
  localparam logic [VAL_W-1:0] ALL_ONES = '1;

  state_t           state, state_nxt;
  logic [VAL_W-1:0] tbl [0:(1<<AW)-1];
  logic [7:0]       gen_idx;
  logic [VAL_W-1:0] term_m1, term_m2;
  logic [VAL_W-1:0] term_new, seed1, seed2;
  logic [VAL_W:0]   sum;
  logic             sat;
  logic             lucas;
  logic             dir_up;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [7:0]       nxt_idx, prv_idx;
  logic [VAL_W-1:0] val_a, val_b;
  logic [ROW_W-1:0] fmt_a, fmt_b;

`ifdef LUCAS_SEED_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                     lucas <= 1'b0;
    else if (start && state != GEN)   lucas <= seed_sel;
  end
`else
  assign lucas = 1'b0;
`endif

  assign seed1 = lucas ? VAL_W'(2) : '0;
  assign seed2 = VAL_W'(1);

  // Next term: seeds for indices 1/2, otherwise a saturating VAL_W+1-bit sum
  always_comb begin
    sum      = {1'b0, term_m1} + {1'b0, term_m2};
    sat      = 1'b0;
    term_new = sum[VAL_W-1:0];
    if (gen_idx == 8'd1)      term_new = seed1;
    else if (gen_idx == 8'd2) term_new = seed2;
    else if (sum[VAL_W]) begin
      term_new = ALL_ONES;
      sat      = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GEN;
      GEN:     if (gen_idx == LAST) state_nxt = DISP;
      DISP:    if (start) state_nxt = GEN;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == GEN);
  assign tick    = (state == DISP) && !pause && (tick_cnt == TICK_MAX);
  assign nxt_idx = (cur_idx == LAST) ? 8'd1 : cur_idx + 8'd1;
  assign prv_idx = (cur_idx == 8'd1) ? LAST : cur_idx - 8'd1;

  // Control: state, generation index, sticky overflow, direction, scroll position
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      gen_idx  <= 8'd1;
      ovf      <= 1'b0;
      dir_up   <= 1'b1;
      tick_cnt <= '0;
      cur_idx  <= 8'd1;
    end else begin
      state <= state_nxt;
      if (dir_toggle) dir_up <= !dir_up;
      if (state != GEN && start) begin
        gen_idx <= 8'd1;
        ovf     <= 1'b0;
      end else if (state == GEN) begin
        gen_idx <= gen_idx + 8'd1;
        if (sat) ovf <= 1'b1;
      end
      if (state == GEN && state_nxt == DISP) begin
        cur_idx  <= 8'd1;
        tick_cnt <= '0;
      end else if (state == DISP && !pause) begin
        if (tick) begin
          tick_cnt <= '0;
          cur_idx  <= dir_up ? nxt_idx : prv_idx;
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

  // Term table and recurrence history carry no reset
  always_ff @(posedge clk) begin
    if (state == GEN) begin
      tbl[gen_idx[AW-1:0]] <= term_new;
      term_m2              <= term_m1;
      term_m1              <= term_new;
    end
  end

  assign val_a = tbl[cur_idx[AW-1:0]];
  assign val_b = tbl[nxt_idx[AW-1:0]];

  fib_row_fmt #(.VAL_W(VAL_W)) u_fmt_a (.idx(cur_idx), .val(val_a), .row(fmt_a));
  fib_row_fmt #(.VAL_W(VAL_W)) u_fmt_b (.idx(nxt_idx), .val(val_b), .row(fmt_b));

  // Rows trail cur_idx by one cycle and freeze outside DISP
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_a <= BANNER_A;
      row_b <= BANNER_B;
    end else if (state == DISP) begin
      row_a <= fmt_a;
      row_b <= fmt_b;
    end
  end

endmodule

// File: tb/tb_fib_scroll_gen.sv
// Bench for fib_scroll_gen: directed vector table, closed-form 8-bit saturation run and a randomized scroll model.
`timescale 1ns/1ps
module tb_fib_scroll_gen;

  localparam int NA = 25, WA = 16, TPA = 4;
  localparam int NB = 20, WB = 8,  TPB = 3;
  localparam logic [127:0] BAN_A = "Press BTN3 to   ";
  localparam logic [127:0] BAN_B = "show a message..";

  logic clk = 1'b0;
  logic reset_n, start_a, tog_a, pause_a, start_b, tog_b, pause_b;
  logic [127:0] row_a_a, row_b_a, row_a_b, row_b_b;
  logic [7:0] cur_a, cur_b;
  logic busy_a, busy_b, ovf_a, ovf_b;
`ifdef LUCAS_SEED_EN
  logic seed_sel = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int m_cur, m_tick;
  bit m_up;

  typedef struct {
    int           cyc;
    bit           p;
    bit           t;
    int           cur;
    logic [127:0] ra;
    logic [127:0] rb;
  } vec_t;

  always #5 clk = ~clk;

  fib_scroll_gen #(.NUM_TERMS(NA), .VAL_W(WA), .TICK_PERIOD(TPA)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .dir_toggle(tog_a), .pause(pause_a),
`ifdef LUCAS_SEED_EN
    .seed_sel(seed_sel),
`endif
    .row_a(row_a_a), .row_b(row_b_a), .cur_idx(cur_a), .busy(busy_a), .ovf(ovf_a)
  );

  fib_scroll_gen #(.NUM_TERMS(NB), .VAL_W(WB), .TICK_PERIOD(TPB)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .dir_toggle(tog_b), .pause(pause_b),
`ifdef LUCAS_SEED_EN
    .seed_sel(seed_sel),
`endif
    .row_a(row_a_b), .row_b(row_b_b), .cur_idx(cur_b), .busy(busy_b), .ovf(ovf_b)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Unbounded Fibonacci value, then clipped to the term width
  function automatic longint fib_true(int k);
    longint a = 0, b = 1, t;
    if (k == 1) return 0;
    for (int i = 3; i <= k; i++) begin
      t = a + b; a = b; b = t;
    end
    return b;
  endfunction

  function automatic longint term_of(int k, int w);
    longint mx, f;
    mx = (longint'(1) << w) - 1;
    f  = fib_true(k);
    return (f > mx) ? mx : f;
  endfunction

  function automatic logic [127:0] fmt(int idx, longint val, int nd);
    string s, h, hi;
    logic [7:0] i8, c;
    logic [63:0] v64;
    logic [127:0] r;
    i8  = 8'(idx);
    v64 = 64'(val);
    h   = $sformatf("%x", v64);
    hi  = $sformatf("%x", i8);
    s   = {"#", hi, ":", h.substr(16 - nd, 15)};
    r   = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < s.len()) c = s[i];
      else             c = 8'h20;
      if (c >= 8'h61 && c <= 8'h66) c = c - 8'h20;
      r[127-8*i -: 8] = c;
    end
    return r;
  endfunction

  function automatic vec_t mk(int cyc, bit p, bit t, int cur, logic [127:0] ra, logic [127:0] rb);
    vec_t v;
    v.cyc = cyc; v.p = p; v.t = t; v.cur = cur; v.ra = ra; v.rb = rb;
    return v;
  endfunction

  // One DISP cycle of DUT A against the scroll model
  task automatic disp_a(input bit p, input bit t);
    logic [127:0] ea, eb;
    int nx;
    nx = m_cur % NA + 1;
    ea = fmt(m_cur, term_of(m_cur, WA), WA / 4);
    eb = fmt(nx, term_of(nx, WA), WA / 4);
    pause_a = p;
    tog_a   = t;
    if (!p) begin
      if (m_tick == TPA - 1) begin
        m_tick = 0;
        m_cur  = m_up ? m_cur % NA + 1 : (m_cur + NA - 2) % NA + 1;
      end else begin
        m_tick++;
      end
    end
    if (t) m_up = !m_up;
    step();
    pause_a = 1'b0;
    tog_a   = 1'b0;
    chk("cur_a", 128'(cur_a), 128'(m_cur));
    chk("row_a_a", row_a_a, ea);
    chk("row_b_a", row_b_a, eb);
    chk("busy_a_disp", 128'(busy_a), 128'(0));
  endtask

  task automatic gen_a();
    int n;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 60) begin
      n++;
      step();
    end
    chk("gen_len_a", 128'(n), 128'(NA));
    chk("ovf_a", 128'(ovf_a), 128'(0));
    m_cur  = 1;
    m_tick = 0;
  endtask

  initial begin
    vec_t tv[$];
    logic [127:0] hold_a, hold_b;
    int n, pc;

    tv.push_back(mk( 1, 0, 0,  1, "#01:0000        ", "#02:0001        "));
    tv.push_back(mk( 3, 0, 0,  2, "#01:0000        ", "#02:0001        "));
    tv.push_back(mk( 1, 0, 0,  2, "#02:0001        ", "#03:0001        "));
    tv.push_back(mk( 4, 0, 0,  3, "#03:0001        ", "#04:0002        "));
    tv.push_back(mk(84, 0, 0, 24, "#18:6FF1        ", "#19:B520        "));
    tv.push_back(mk( 4, 0, 0, 25, "#19:B520        ", "#01:0000        "));
    tv.push_back(mk( 4, 0, 0,  1, "#01:0000        ", "#02:0001        "));
    tv.push_back(mk( 1, 0, 1,  1, "#01:0000        ", "#02:0001        "));
    tv.push_back(mk( 2, 0, 0, 25, "#01:0000        ", "#02:0001        "));
    tv.push_back(mk( 1, 0, 0, 25, "#19:B520        ", "#01:0000        "));
    tv.push_back(mk( 2, 0, 0, 25, "#19:B520        ", "#01:0000        "));
    tv.push_back(mk( 1, 0, 1, 24, "#19:B520        ", "#01:0000        "));
    tv.push_back(mk( 4, 0, 0, 25, "#18:6FF1        ", "#19:B520        "));
    tv.push_back(mk( 1, 0, 0, 25, "#19:B520        ", "#01:0000        "));
    tv.push_back(mk(20, 1, 0, 25, "#19:B520        ", "#01:0000        "));
    tv.push_back(mk( 2, 0, 0, 25, "#19:B520        ", "#01:0000        "));
    tv.push_back(mk( 1, 0, 0,  1, "#19:B520        ", "#01:0000        "));
    tv.push_back(mk( 1, 0, 0,  1, "#01:0000        ", "#02:0001        "));

    reset_n = 1'b0;
    start_a = 1'b0; tog_a = 1'b0; pause_a = 1'b0;
    start_b = 1'b0; tog_b = 1'b0; pause_b = 1'b0;
    m_up = 1'b1;
    step(); step();
    reset_n = 1'b1;
    step();

    chk("rst_row_a", row_a_a, BAN_A);
    chk("rst_row_b", row_b_a, BAN_B);
    chk("rst_cur", 128'(cur_a), 128'(1));
    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_ovf", 128'(ovf_a), 128'(0));
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle_row_a", row_a_a, BAN_A);
      chk("idle_row_b", row_b_a, BAN_B);
      chk("idle_busy", 128'(busy_a), 128'(0));
    end

    gen_a();
    foreach (tv[i]) begin
      for (int c = 0; c < tv[i].cyc; c++) disp_a(tv[i].p, tv[i].t);
      chk($sformatf("vec%0d_cur", i), 128'(cur_a), 128'(tv[i].cur));
      chk($sformatf("vec%0d_row_a", i), row_a_a, tv[i].ra);
      chk($sformatf("vec%0d_row_b", i), row_b_a, tv[i].rb);
    end

    for (int i = 0; i < 300; i++)
      disp_a(($urandom % 4) == 0, ($urandom % 8) == 0);

    // Restart from DISP: rows hold their last text through GEN
    hold_a = fmt(m_cur, term_of(m_cur, WA), WA / 4);
    hold_b = fmt(m_cur % NA + 1, term_of(m_cur % NA + 1, WA), WA / 4);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 60) begin
      chk("hold_row_a", row_a_a, hold_a);
      chk("hold_row_b", row_b_a, hold_b);
      n++;
      step();
    end
    chk("regen_len_a", 128'(n), 128'(NA));
    m_cur = 1; m_tick = 0;
    for (int i = 0; i < 12; i++) disp_a(1'b0, 1'b0);

    // Reset in DISP, then reset in GEN
    reset_n = 1'b0; step(); reset_n = 1'b1;
    chk("rd_row_a", row_a_a, BAN_A);
    chk("rd_row_b", row_b_a, BAN_B);
    chk("rd_cur", 128'(cur_a), 128'(1));
    m_up = 1'b1;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b0; step(); reset_n = 1'b1;
    chk("rg_busy", 128'(busy_a), 128'(0));
    chk("rg_row_a", row_a_a, BAN_A);
    chk("rg_cur", 128'(cur_a), 128'(1));
    gen_a();
    for (int i = 0; i < 10; i++) disp_a(1'b0, 1'b0);

    // 8-bit instance: saturation and sticky overflow
    chk("b_idle_row_a", row_a_b, BAN_A);
    start_b = 1'b1; step(); start_b = 1'b0;
    chk("b_busy", 128'(busy_b), 128'(1));
    chk("b_ovf0", 128'(ovf_b), 128'(0));
    for (int k = 1; k <= NB; k++) begin
      step();
      chk($sformatf("b_ovf_k%0d", k), 128'(ovf_b), 128'(fib_true(k) > 255));
    end
    chk("b_busy_end", 128'(busy_b), 128'(0));
    for (int c = 1; c <= NB * TPB + 6; c++) begin
      step();
      pc = ((c - 1) / TPB) % NB + 1;
      chk("b_cur", 128'(cur_b), 128'((c / TPB) % NB + 1));
      chk("b_row_a", row_a_b, fmt(pc, term_of(pc, WB), 2));
      chk("b_row_b", row_b_b, fmt(pc % NB + 1, term_of(pc % NB + 1, WB), 2));
      if (pc == 14) chk("b_term14", row_a_b, "#0E:E9          ");
      if (pc == 15) chk("b_term15", row_a_b, "#0F:FF          ");
      if (pc == 20) chk("b_term20", row_a_b, "#14:FF          ");
    end
    chk("b_ovf_sticky", 128'(ovf_b), 128'(1));
    start_b = 1'b1; step(); start_b = 1'b0;
    chk("b_ovf_clr", 128'(ovf_b), 128'(0));
    chk("b_busy_re", 128'(busy_b), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
